// File: rtl/controlador_interrupcao_multicanal.sv
// Multi-channel interrupt controller: latches N_IRQ requests, lowest index wins, ack captures cause/pc/data, clr releases.
// Optional macro INTC_EDGE_EN selects sticky edge-triggered pending; default build samples request levels.
module controlador_interrupcao_multicanal #(
  parameter int N_IRQ  = 4,
  parameter int DATA_W = 32,
  parameter int PC_W   = 26
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_IRQ-1:0]        irq,
  input  logic [N_IRQ*DATA_W-1:0] irq_data,
  input  logic [N_IRQ-1:0]        mask,
  input  logic [PC_W-1:0]         pc,
  input  logic                    ack,
  input  logic                    clr,
  output logic                    intr,
  output logic [DATA_W-1:0]       data,
  output logic [31:0]             cause,
  output logic [31:0]             pcBckp
);
  localparam int SEL_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t            state_q, state_d;
  logic [N_IRQ-1:0]  pending_q, pending_d, eligible;
  logic [DATA_W-1:0] data_reg_q [N_IRQ];
  logic [DATA_W-1:0] data_reg_d [N_IRQ];
  logic [SEL_W-1:0]  sel_q, sel_d, winner;
  logic [DATA_W-1:0] data_q, data_d;
  logic [31:0]       cause_q, cause_d, pc_bckp_q, pc_bckp_d;

  assign eligible = pending_q & mask;

  // Scan downwards so the lowest eligible index is the last assignment.
  always_comb begin
    winner = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = SEL_W'(i);
    end
  end

`ifdef INTC_EDGE_EN
  logic [N_IRQ-1:0] irq_q, rise, ack_clr;
  logic             ack_fire;

  assign rise     = irq & ~irq_q;
  assign ack_fire = (state_q == REQ) && ack;

  // A new edge on the acked channel in the same cycle re-arms it, so the event survives.
  always_comb begin
    ack_clr    = '0;
    pending_d  = pending_q;
    data_reg_d = data_reg_q;
    if (ack_fire) ack_clr[sel_q] = 1'b1;
    for (int i = 0; i < N_IRQ; i++) begin
      pending_d[i] = rise[i] | (pending_q[i] & ~ack_clr[i]);
      if (rise[i]) data_reg_d[i] = irq_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= '0;
    else        irq_q <= irq;
  end
`else
  always_comb begin
    pending_d  = irq;
    data_reg_d = data_reg_q;
    for (int i = 0; i < N_IRQ; i++) begin
      if (irq[i]) data_reg_d[i] = irq_data[i*DATA_W +: DATA_W];
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    data_d    = data_q;
    cause_d   = cause_q;
    pc_bckp_d = pc_bckp_q;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d = REQ;
          sel_d   = winner;
        end
      end
      REQ: begin
        if (ack) begin
          state_d   = SERVICE;
          cause_d   = 32'(sel_q) + 32'd1;
          pc_bckp_d = 32'(pc);
          data_d    = data_reg_q[sel_q];
        end
      end
      SERVICE: begin
        if (clr) begin
          state_d = IDLE;
          cause_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      sel_q     <= '0;
      data_q    <= '0;
      cause_q   <= '0;
      pc_bckp_q <= '0;
      for (int i = 0; i < N_IRQ; i++) data_reg_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      sel_q      <= sel_d;
      data_q     <= data_d;
      cause_q    <= cause_d;
      pc_bckp_q  <= pc_bckp_d;
      data_reg_q <= data_reg_d;
    end
  end

  assign intr   = (state_q == REQ);
  assign data   = data_q;
  assign cause  = cause_q;
  assign pcBckp = pc_bckp_q;

endmodule

// File: tb/tb_controlador_interrupcao_multicanal.sv
// Scoreboard bench for controlador_interrupcao_multicanal; works with or without INTC_EDGE_EN.
module tb_controlador_interrupcao_multicanal;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int PW = 26;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    irq;
  logic [N*DW-1:0] irq_data;
  logic [N-1:0]    mask;
  logic [PW-1:0]   pc;
  logic            ack, clr;
  logic            intr;
  logic [DW-1:0]   data;
  logic [31:0]     cause, pcBckp;

  controlador_interrupcao_multicanal #(.N_IRQ(N), .DATA_W(DW), .PC_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .irq_data(irq_data), .mask(mask),
    .pc(pc), .ack(ack), .clr(clr), .intr(intr), .data(data), .cause(cause), .pcBckp(pcBckp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cause;
    logic [31:0] data;
    logic [31:0] pcb;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [31:0] v);
    irq_data[ch*DW +: DW] = v;
  endtask

  task automatic expect_svc(input int ch, input logic [31:0] d, input logic [PW-1:0] p);
    exp_t e;
    e.cause = 32'(ch + 1);
    e.data  = d;
    e.pcb   = 32'(p);
    sb.push_back(e);
  endtask

  task automatic wait_intr(input string tag);
    for (int i = 0; i < 20 && !intr; i++) step();
    check({tag, "_intr_up"}, 32'(intr), 32'd1);
  endtask

  task automatic ack_phase(input string tag, input bit drop, input bit with_clr, input logic [N-1:0] raise);
    exp_t e;
    int   ch;
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty", tag);
      $fatal(1);
    end
    e  = sb.pop_front();
    ch = int'(e.cause) - 1;
    pc = e.pcb[PW-1:0];
    if (drop) irq[ch] = 1'b0;
    irq = irq | raise;
    ack = 1'b1;
    clr = with_clr;
    step();
    ack = 1'b0;
    clr = 1'b0;
    check({tag, "_intr_dn"}, 32'(intr), 32'd0);
    check({tag, "_cause"}, cause, e.cause);
    check({tag, "_data"}, data, e.data);
    check({tag, "_pcbckp"}, pcBckp, e.pcb);
    last_data = e.data;
  endtask

  task automatic clr_phase(input string tag);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check({tag, "_clr_cause"}, cause, 32'd0);
    check({tag, "_clr_data"}, data, last_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; irq = '0; irq_data = '0; mask = '1; pc = '0; ack = 1'b0; clr = 1'b0;
    step(); step();
    check("rst_intr", 32'(intr), 32'd0);
    check("rst_data", data, 32'd0);
    check("rst_cause", cause, 32'd0);
    check("rst_pcbckp", pcBckp, 32'd0);
    rst_n = 1'b1;
    step();

    // single request: pulse on channel 2, two edges to intr
    set_data(2, 32'hCAFE0002);
    expect_svc(2, 32'hCAFE0002, 26'h123);
    irq = 4'b0100;
    step();
    irq = '0;
    check("single_lat1", 32'(intr), 32'd0);
    step();
    check("single_lat2", 32'(intr), 32'd1);
    ack_phase("single", 1'b1, 1'b0, '0);
    clr_phase("single");

    // priority: channels 1 and 3 together
    set_data(1, 32'h1111_0001);
    set_data(3, 32'h3333_0003);
    expect_svc(1, 32'h1111_0001, 26'h2000);
    expect_svc(3, 32'h3333_0003, 26'h3FF_FFFF);
    irq = 4'b1010;
    wait_intr("prio1");
    ack_phase("prio1", 1'b1, 1'b0, '0);
    clr_phase("prio1");
    wait_intr("prio2");
    ack_phase("prio2", 1'b1, 1'b0, '0);
    clr_phase("prio2");

    // mask: channel 1 held but disabled
    mask = 4'b1101;
    set_data(1, 32'hABCD_0101);
    irq = 4'b0010;
    step(); step();
    check("mask_hold1", 32'(intr), 32'd0);
    step(); step();
    check("mask_hold2", 32'(intr), 32'd0);
    mask = 4'hF;
    expect_svc(1, 32'hABCD_0101, 26'h0BEEF);
    wait_intr("mask");
    ack_phase("mask", 1'b1, 1'b0, '0);
    clr_phase("mask");

    // handshake corner cases
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("hs_ack_idle_intr", 32'(intr), 32'd0);
    check("hs_ack_idle_cause", cause, 32'd0);
    set_data(0, 32'h0000_5A5A);
    expect_svc(0, 32'h0000_5A5A, 26'h0777);
    irq = 4'b0001;
    wait_intr("hs");
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("hs_clr_req_intr", 32'(intr), 32'd1);
    check("hs_clr_req_cause", cause, 32'd0);
    ack_phase("hs_ackclr", 1'b1, 1'b1, '0);
    clr_phase("hs");
    step();

`ifdef INTC_EDGE_EN
    // held request counts once; re-pulse on the ack edge is not lost
    set_data(0, 32'hE0E0_0001);
    expect_svc(0, 32'hE0E0_0001, 26'h0010);
    irq = 4'b0001;
    wait_intr("edge_hold");
    ack_phase("edge_hold", 1'b0, 1'b0, '0);
    clr_phase("edge_hold");
    for (int i = 0; i < 6; i++) begin
      step();
      check("edge_hold_quiet", 32'(intr), 32'd0);
    end
    irq = '0;
    step();
    set_data(0, 32'hE0E0_0002);
    expect_svc(0, 32'hE0E0_0002, 26'h0020);
    irq = 4'b0001;
    wait_intr("edge_rep1");
    irq = '0;
    step();
    set_data(0, 32'hE0E0_0003);
    expect_svc(0, 32'hE0E0_0003, 26'h0030);
    ack_phase("edge_rep1", 1'b0, 1'b0, 4'b0001);
    clr_phase("edge_rep1");
    wait_intr("edge_rep2");
    ack_phase("edge_rep2", 1'b1, 1'b0, '0);
    clr_phase("edge_rep2");
`else
    // level held across clr gets serviced again
    set_data(0, 32'h1E1E_0001);
    expect_svc(0, 32'h1E1E_0001, 26'h0010);
    expect_svc(0, 32'h1E1E_0001, 26'h0020);
    irq = 4'b0001;
    wait_intr("lvl1");
    ack_phase("lvl1", 1'b0, 1'b0, '0);
    clr_phase("lvl1");
    wait_intr("lvl2");
    ack_phase("lvl2", 1'b1, 1'b0, '0);
    clr_phase("lvl2");
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      check("quiet_after", 32'(intr), 32'd0);
    end

    // asynchronous reset while in REQ
    set_data(1, 32'h7777_0001);
    irq = 4'b0010;
    wait_intr("rst_mid");
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_intr", 32'(intr), 32'd0);
    check("rst_mid_data", data, 32'd0);
    check("rst_mid_cause", cause, 32'd0);
    check("rst_mid_pcbckp", pcBckp, 32'd0);
    irq = '0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_mid_quiet", 32'(intr), 32'd0);
    end
    set_data(3, 32'hF00D_0003);
    expect_svc(3, 32'hF00D_0003, 26'h1ABCDE);
    irq = 4'b1000;
    step();
    irq = '0;
    wait_intr("recover");
    ack_phase("recover", 1'b1, 1'b0, '0);
    clr_phase("recover");

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
